image_binarize: RTL and testbench

//  Second stage of the QR capture chain. It reads the 8-bit grayscale frame that the

---
 rtl/image_binarize.sv | 139 +++++++++++++
 tb/tb_image_binarize.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/image_binarize.sv
// Two-pass frame binarizer: mean of all pixels (or a manual level), then a 1-bit/pixel packed bitmap.
// Latency: done 2*PIX_NUM+4 cycles after start; port b reads are 1-cycle, and bitmap bytes are written as they complete.
module image_binarize #(
  parameter int LOG2_PIX = 16,
  parameter int ADDR_W   = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                man_en,
  input  logic [7:0]          man_thr,
  output logic                busy,
  output logic                done,
  output logic [7:0]          thr_out,
  output logic                enb,
  output logic                web,
  output logic [ADDR_W-1:0]   addrb,
  output logic [7:0]          dinb,
  input  logic [7:0]          doutb,
  output logic                bwe,
  output logic [LOG2_PIX-4:0] baddr,
  output logic [7:0]          bdin
);

  localparam int SUM_W = LOG2_PIX + 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((1 << LOG2_PIX) - 1);

  typedef enum logic [2:0] {S_IDLE, S_SUM, S_CALC, S_BIN, S_DONE} state_t;

  state_t              state_q;
  logic                busy_q, done_q, man_en_q;
  logic [7:0]          man_thr_q, thr_q;
  logic                enb_q, vld_q, lst_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SUM_W-1:0]    sum_q;
  logic [LOG2_PIX-1:0] pix_q;
  logic [6:0]          sr_q;
  logic                bwe_q;
  logic [LOG2_PIX-4:0] baddr_q;
  logic [7:0]          bdin_q;

  logic [SUM_W-1:0] sum_d;
  logic             bit_d;
  logic [7:0]       byte_d;
  logic             addr_last;

  always_comb begin
    sum_d     = sum_q + SUM_W'(doutb);
    bit_d     = (doutb < thr_q);
    byte_d    = {sr_q, bit_d};
    addr_last = (addr_q == LAST_ADDR);
  end

  // vld_q/lst_q mark the cycle in which doutb carries the data of the previous cycle's read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      man_en_q  <= 1'b0;
      man_thr_q <= '0;
      thr_q     <= '0;
      enb_q     <= 1'b0;
      vld_q     <= 1'b0;
      lst_q     <= 1'b0;
      addr_q    <= '0;
      sum_q     <= '0;
      pix_q     <= '0;
      sr_q      <= '0;
      bwe_q     <= 1'b0;
      baddr_q   <= '0;
      bdin_q    <= '0;
    end else begin
      done_q <= 1'b0;
      bwe_q  <= 1'b0;
      vld_q  <= enb_q;
      lst_q  <= enb_q && addr_last;
      if (enb_q) begin
        if (addr_last) enb_q  <= 1'b0;
        else           addr_q <= addr_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            man_en_q  <= man_en;
            man_thr_q <= man_thr;
            busy_q    <= 1'b1;
            sum_q     <= '0;
            enb_q     <= 1'b1;
            addr_q    <= '0;
            state_q   <= S_SUM;
          end
        end
        S_SUM: begin
          if (vld_q) sum_q <= sum_d;
          if (lst_q) state_q <= S_CALC;
        end
        S_CALC: begin
          thr_q   <= man_en_q ? man_thr_q : sum_q[SUM_W-1:LOG2_PIX];
          enb_q   <= 1'b1;
          addr_q  <= '0;
          pix_q   <= '0;
          sr_q    <= '0;
          state_q <= S_BIN;
        end
        S_BIN: begin
          if (vld_q) begin
            sr_q  <= byte_d[6:0];
            pix_q <= pix_q + 1'b1;
            if (&pix_q[2:0]) begin
              bwe_q   <= 1'b1;
              baddr_q <= pix_q[LOG2_PIX-1:3];
              bdin_q  <= byte_d;
            end
          end
          if (lst_q) state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign thr_out = thr_q;
  assign enb     = enb_q;
  assign web     = 1'b0;
  assign addrb   = addr_q;
  assign dinb    = 8'h00;
  assign bwe     = bwe_q;
  assign baddr   = baddr_q;
  assign bdin    = bdin_q;

endmodule

// File: tb/tb_image_binarize.sv
// Bench for image_binarize on a 16-pixel frame, with a behavioural frame RAM and a bitmap-byte scoreboard.
module tb_image_binarize;
  localparam int LOG2_PIX = 4;
  localparam int ADDR_W   = 18;
  localparam int NPIX     = 1 << LOG2_PIX;

  logic clk = 1'b0;
  logic rst_n, start, man_en;
  logic [7:0] man_thr;
  logic busy, done, enb, web, bwe;
  logic [7:0] thr_out, dinb, doutb, bdin;
  logic [ADDR_W-1:0] addrb;
  logic [LOG2_PIX-4:0] baddr;

  image_binarize #(.LOG2_PIX(LOG2_PIX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .man_en(man_en), .man_thr(man_thr),
    .busy(busy), .done(done), .thr_out(thr_out), .enb(enb), .web(web),
    .addrb(addrb), .dinb(dinb), .doutb(doutb), .bwe(bwe), .baddr(baddr), .bdin(bdin)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [NPIX];
  always @(posedge clk) if (enb) doutb <= mem[addrb[LOG2_PIX-1:0]];

  int total = 0;
  int bad = 0;
  logic [8:0] sb [$];

  int o_done_cyc, o_enb_cnt, o_bwe_cnt, o_bwe_sum, o_tie_bad, o_busy_bad, o_post_bad;
  logic [40:0] o_rst_vec;

  task automatic push_expected(input logic me, input logic [7:0] mt);
    int s;
    logic [7:0] thr, byt;
    s = 0;
    for (int i = 0; i < NPIX; i++) s += mem[i];
    thr = me ? mt : 8'(s / NPIX);
    for (int b = 0; b < NPIX / 8; b++) begin
      byt = 8'h00;
      for (int k = 0; k < 8; k++)
        if (mem[b*8+k] < thr) byt[7-k] = 1'b1;
      sb.push_back({1'(b), byt});
    end
  endtask

  // Drives one run; start is sampled at the edge numbered cycle 0. Observations land in o_* variables.
  task automatic run_frame(input logic me, input logic [7:0] mt, input bit extra, input int rst_cyc);
    int budget;
    logic [8:0] exp_b;
    budget = (rst_cyc >= 0) ? 45 : 60;
    o_done_cyc = -1; o_enb_cnt = 0; o_bwe_cnt = 0; o_bwe_sum = 0;
    o_tie_bad = 0; o_busy_bad = 0; o_post_bad = 0; o_rst_vec = '1;
    push_expected(me, mt);
    @(negedge clk);
    start = 1'b1; man_en = me; man_thr = mt;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc <= budget; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (enb === 1'b1) o_enb_cnt++;
      if (web !== 1'b0 || dinb !== 8'h00) o_tie_bad++;
      if (bwe === 1'b1) begin
        o_bwe_cnt++;
        if (cyc <= NPIX) o_bwe_sum++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_write: cycle %0d baddr=%0d bdin=%02h, no write expected", cyc, baddr, bdin);
        end else begin
          exp_b = sb.pop_front();
          if ({baddr, bdin} !== exp_b) begin
            bad++;
            $display("FAIL sb_byte: cycle %0d got baddr=%0d bdin=%02h, want baddr=%0d bdin=%02h",
                     cyc, baddr, bdin, exp_b[8], exp_b[7:0]);
          end
        end
      end
      if (rst_cyc < 0 || cyc <= rst_cyc) begin
        if (cyc < 2*NPIX+4 && busy !== 1'b1) o_busy_bad++;
        if (cyc == 2*NPIX+4 && busy !== 1'b0) o_busy_bad++;
      end
      if (done === 1'b1 && o_done_cyc < 0) o_done_cyc = cyc;
      if (o_done_cyc >= 0 && cyc == o_done_cyc + 1) begin
        if (done !== 1'b0 || busy !== 1'b0) o_post_bad++;
        break;
      end
      if (cyc == rst_cyc + 1) begin
        o_rst_vec = {busy, done, thr_out, enb, addrb, bwe, baddr, bdin};
        rst_n = 1'b1;
      end
      if (cyc == rst_cyc) rst_n = 1'b0;
      start = extra && (cyc == 4 || cyc == 19);
      if (start) begin
        man_en = 1'b1; man_thr = 8'h00;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; man_en = 1'b0; man_thr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, thr_out, enb, addrb, bwe, baddr, bdin, web, dinb} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b thr=%02h enb=%b addrb=%0h bwe=%b baddr=%0h bdin=%02h web=%b dinb=%02h, want all 0",
               busy, done, thr_out, enb, addrb, bwe, baddr, bdin, web, dinb);
    end
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_ramp_auto;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i * 16);
    run_frame(1'b0, 8'h00, 1'b0, -1);
    total++; if (o_done_cyc !== 36) begin bad++; $display("FAIL ramp_done_cycle: got %0d want 36", o_done_cyc); end
    total++; if (thr_out !== 8'd120) begin bad++; $display("FAIL ramp_thr: got %0d want 120", thr_out); end
    total++; if (o_bwe_cnt !== 2) begin bad++; $display("FAIL ramp_bwe_count: got %0d want 2", o_bwe_cnt); end
    total++; if (o_enb_cnt !== 32) begin bad++; $display("FAIL ramp_enb_cycles: got %0d want 32", o_enb_cnt); end
    total++; if (o_tie_bad !== 0) begin bad++; $display("FAIL ramp_web_dinb: %0d nonzero cycles, want 0", o_tie_bad); end
    total++; if (o_bwe_sum !== 0) begin bad++; $display("FAIL ramp_bwe_in_sum: got %0d want 0", o_bwe_sum); end
    total++; if (o_busy_bad !== 0) begin bad++; $display("FAIL ramp_busy: %0d bad cycles, want 0", o_busy_bad); end
    total++; if (o_post_bad !== 0) begin bad++; $display("FAIL ramp_done_pulse: %0d bad, want 0", o_post_bad); end
  endtask

  task automatic test_manual_zero;
    run_frame(1'b1, 8'h00, 1'b0, -1);
    total++; if (thr_out !== 8'd0) begin bad++; $display("FAIL man0_thr: got %0d want 0", thr_out); end
    total++; if (o_bwe_cnt !== 2) begin bad++; $display("FAIL man0_bwe_count: got %0d want 2", o_bwe_cnt); end
    total++; if (o_done_cyc !== 36) begin bad++; $display("FAIL man0_done_cycle: got %0d want 36", o_done_cyc); end
  endtask

  task automatic test_const_ff;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'hFF;
    run_frame(1'b0, 8'h00, 1'b0, -1);
    total++; if (thr_out !== 8'd255) begin bad++; $display("FAIL const_thr: got %0d want 255", thr_out); end
    total++; if (o_bwe_cnt !== 2) begin bad++; $display("FAIL const_bwe_count: got %0d want 2", o_bwe_cnt); end
    mem[3] = 8'h00;
    run_frame(1'b1, 8'hFF, 1'b0, -1);
    total++; if (thr_out !== 8'd255) begin bad++; $display("FAIL dark_thr: got %0d want 255", thr_out); end
    total++; if (o_bwe_cnt !== 2) begin bad++; $display("FAIL dark_bwe_count: got %0d want 2", o_bwe_cnt); end
  endtask

  task automatic test_extra_start;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i * 16);
    run_frame(1'b0, 8'h00, 1'b1, -1);
    total++; if (o_done_cyc !== 36) begin bad++; $display("FAIL extra_done_cycle: got %0d want 36", o_done_cyc); end
    total++; if (thr_out !== 8'd120) begin bad++; $display("FAIL extra_thr: got %0d want 120", thr_out); end
    total++; if (o_bwe_cnt !== 2) begin bad++; $display("FAIL extra_bwe_count: got %0d want 2", o_bwe_cnt); end
    total++; if (o_busy_bad !== 0) begin bad++; $display("FAIL extra_busy: %0d bad cycles, want 0", o_busy_bad); end
    total++; if (o_enb_cnt !== 32) begin bad++; $display("FAIL extra_enb_cycles: got %0d want 32", o_enb_cnt); end
  endtask

  task automatic test_abort_reset;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(($urandom_range(0, 255)));
    run_frame(1'b0, 8'h00, 1'b0, 29);
    total++; if (o_rst_vec !== '0) begin bad++; $display("FAIL abort_outputs: got %h want 0", o_rst_vec); end
    total++; if (o_bwe_cnt !== 1) begin bad++; $display("FAIL abort_bwe_count: got %0d want 1", o_bwe_cnt); end
    total++; if (o_done_cyc !== -1) begin bad++; $display("FAIL abort_done: done seen at cycle %0d, want none", o_done_cyc); end
    total++; if (sb.size() !== 1) begin bad++; $display("FAIL abort_pending: got %0d pending bytes want 1", sb.size()); end
    sb.delete();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i * 16);
    run_frame(1'b0, 8'h00, 1'b0, -1);
    total++; if (o_done_cyc !== 36) begin bad++; $display("FAIL rerun_done_cycle: got %0d want 36", o_done_cyc); end
    total++; if (thr_out !== 8'd120) begin bad++; $display("FAIL rerun_thr: got %0d want 120", thr_out); end
    total++; if (o_bwe_cnt !== 2) begin bad++; $display("FAIL rerun_bwe_count: got %0d want 2", o_bwe_cnt); end
  endtask

  initial begin
    test_reset();
    test_ramp_auto();
    test_manual_zero();
    test_const_ff();
    test_extra_start();
    test_abort_reset();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending bytes want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
